compress_seq: RTL and testbench

Job sequencer for the requantize/compress stage. On a start command it streams `len` accumulator sums out of the accumulator buffer and saturates each from SUM_WIDTH bits to int8 using the standard compress rule. It packs four int8 results per 32-bit word and presents the words on a valid/ready stream toward the output buffer or DMA. It also counts saturation events per job.

---
 rtl/compress_seq.sv | 216 +++++++++++++++++++++
 tb/tb_compress_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/compress_seq.sv
// Requantize/compress job sequencer: streams accumulator sums, saturates them to int8,
// packs four lanes per 32-bit word onto a valid/ready stream and counts saturations.
module compress_seq #(
    parameter int SUM_WIDTH  = 20,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [ADDR_WIDTH-1:0]       rd_base,
    input  logic [ADDR_WIDTH:0]         len,
    output logic                        busy,
    output logic                        done,
    output logic                        acc_rd_en,
    output logic [ADDR_WIDTH-1:0]       acc_rd_addr,
    input  logic signed [SUM_WIDTH-1:0] acc_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_data,
    output logic                        out_last,
    output logic [ADDR_WIDTH:0]         sat_cnt
);

    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [CW-1:0]          rd_rem_q, rd_rem_d;
    logic [CW-1:0]          arr_rem_q, arr_rem_d;
    logic                   infl_q, infl_d;
    logic [31:0]            pack_q, pack_d;
    logic [2:0]             fill_q, fill_d;
    logic                   pack_last_q, pack_last_d;
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic [CW-1:0]          sat_cnt_q, sat_cnt_d;
    logic                   done_q, done_d;

    logic       rd_en;
    logic       out_free;
    logic       accept;
    logic       loaded;
    logic       final_byte;
    logic [7:0] arr_byte;
    logic       arr_sat;

    function automatic logic signed [SUM_WIDTH-1:0] sum_q(input logic signed [SUM_WIDTH-1:0] sum);
        return sum >>> 8;
    endfunction

    function automatic logic is_saturated(input logic signed [SUM_WIDTH-1:0] sum);
        logic signed [SUM_WIDTH-1:0] q;
        q = sum_q(sum);
        return (q > SUM_WIDTH'(127)) || (q < SUM_WIDTH'(-128));
    endfunction

    function automatic logic [7:0] compress_byte(input logic signed [SUM_WIDTH-1:0] sum);
        logic signed [SUM_WIDTH-1:0] q;
        q = sum_q(sum);
        if (q > SUM_WIDTH'(127)) begin
            return 8'h7F;
        end else if (q < SUM_WIDTH'(-128)) begin
            return 8'h80;
        end
        return q[7:0];
    endfunction

    always_comb begin
        accept     = out_valid_q && out_ready;
        out_free   = !out_valid_q || out_ready;
        arr_byte   = compress_byte(acc_rd_data);
        arr_sat    = is_saturated(acc_rd_data);
        final_byte = (arr_rem_q == CW'(1));
        // A read may only issue if its byte is guaranteed a slot when it lands.
        rd_en      = (state_q == RUN) && (rd_rem_q != '0) &&
                     ((({1'b0, fill_q} + {3'b000, infl_q}) < 4'd4) || out_free);
    end

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rd_rem_d    = rd_rem_q;
        arr_rem_d   = arr_rem_q;
        infl_d      = rd_en;
        pack_d      = pack_q;
        fill_d      = fill_q;
        pack_last_d = pack_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sat_cnt_d   = sat_cnt_q;
        done_d      = 1'b0;
        loaded      = 1'b0;

        if (accept) begin
            out_valid_d = 1'b0;
        end

        if (fill_q == 3'd4 && out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = pack_q;
            out_last_d  = pack_last_q;
            loaded      = 1'b1;
            pack_d      = '0;
            fill_d      = 3'd0;
            pack_last_d = 1'b0;
        end

        if (infl_q) begin
            for (int i = 0; i < 4; i++) begin
                if (fill_d[1:0] == 2'(i)) begin
                    pack_d[8*i +: 8] = arr_byte;
                end
            end
            fill_d    = fill_d + 3'd1;
            arr_rem_d = arr_rem_q - CW'(1);
            if (arr_sat) begin
                sat_cnt_d = sat_cnt_q + CW'(1);
            end
            // Group closes on its 4th byte or on the job's final (possibly partial) byte.
            if (fill_d == 3'd4 || final_byte) begin
                if (out_free && !loaded) begin
                    out_valid_d = 1'b1;
                    out_data_d  = pack_d;
                    out_last_d  = final_byte;
                    pack_d      = '0;
                    fill_d      = 3'd0;
                    pack_last_d = 1'b0;
                end else begin
                    fill_d      = 3'd4;
                    pack_last_d = final_byte;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    sat_cnt_d = '0;
                    if (len != '0) begin
                        state_d     = RUN;
                        rd_addr_d   = rd_base;
                        rd_rem_d    = len;
                        arr_rem_d   = len;
                        pack_d      = '0;
                        fill_d      = 3'd0;
                        pack_last_d = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (rd_en) begin
                    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
                    rd_rem_d  = rd_rem_q - CW'(1);
                    if (rd_rem_q == CW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (accept && out_last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            rd_rem_q    <= '0;
            arr_rem_q   <= '0;
            infl_q      <= 1'b0;
            pack_q      <= '0;
            fill_q      <= 3'd0;
            pack_last_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sat_cnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rd_rem_q    <= rd_rem_d;
            arr_rem_q   <= arr_rem_d;
            infl_q      <= infl_d;
            pack_q      <= pack_d;
            fill_q      <= fill_d;
            pack_last_q <= pack_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sat_cnt_q   <= sat_cnt_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign acc_rd_en   = rd_en;
    assign acc_rd_addr = rd_addr_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign sat_cnt     = sat_cnt_q;

endmodule

// File: tb/tb_compress_seq.sv
// Bench for compress_seq: accumulator memory model plus an arithmetic reference of the
// expected word stream, checked every cycle, with literal expectations for directed jobs.
module tb_compress_seq;

    localparam int SW = 20;
    localparam int AW = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [AW-1:0]        rd_base = '0;
    logic [AW:0]          len = '0;
    logic                 busy, done, acc_rd_en;
    logic [AW-1:0]        acc_rd_addr;
    logic signed [SW-1:0] acc_rd_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [31:0]          out_data;
    logic                 out_last;
    logic [AW:0]          sat_cnt;

    compress_seq #(.SUM_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_base(rd_base), .len(len),
        .busy(busy), .done(done), .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
        .acc_rd_data(acc_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [SW-1:0] mem [256];
    int            cyc = 0;
    logic          rd_pend = 1'b0;
    logic [AW-1:0] rd_pend_addr = '0;
    int            ready_mode = 1;

    logic [31:0]   expq [$];
    logic [31:0]   got [$];
    int            exp_sat = 0;
    logic [AW-1:0] exp_addr = '0;
    int            reads_left = 0;
    int            reads_done = 0;
    int            words_acc = 0;
    bit            done_due = 1'b0;
    bit            job_done_seen = 1'b0;
    int            start_cyc = 0;
    int            first_valid_cyc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [SW-1:0] v, output bit s);
        int val;
        int q;
        val = int'($signed(v));
        q = val >>> 8;
        s = (q > 127) || (q < -128);
        if (q > 127) return 8'h7F;
        if (q < -128) return 8'h80;
        return q[7:0];
    endfunction

    task automatic build_model(input logic [AW-1:0] b, input int n);
        logic [31:0] w;
        logic [7:0]  by;
        bit          s;
        expq.delete();
        exp_sat = 0;
        for (int i = 0; i < n; i += 4) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                if (i + j < n) begin
                    by = model_byte(mem[(int'(b) + i + j) % 256], s);
                    w = w | (32'(by) << (8 * j));
                    if (s) exp_sat++;
                end
            end
            expq.push_back(w);
        end
    endtask

    // Memory returns data the cycle after a read; otherwise junk.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rd_pend) acc_rd_data = mem[rd_pend_addr];
        else acc_rd_data = SW'($urandom);
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            rd_pend = 1'b0;
        end else begin
            chk("done_pulse", done, done_due);
            if (done_due) begin
                chk("busy_at_done", busy, 0);
                chk("sat_cnt_at_done", sat_cnt, exp_sat);
                job_done_seen = 1'b1;
            end
            done_due = 1'b0;
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (expq.size() == 0) begin
                    chk("spurious_valid", out_valid, 0);
                end else begin
                    chk("out_data", out_data, expq[0]);
                    chk("out_last", out_last, expq.size() == 1);
                    if (out_ready) begin
                        got.push_back(out_data);
                        void'(expq.pop_front());
                        words_acc++;
                        if (out_last) done_due = 1'b1;
                    end
                end
            end
            if (acc_rd_en) begin
                chk("rd_in_job", reads_left > 0, 1);
                chk("rd_addr", acc_rd_addr, exp_addr);
                exp_addr++;
                reads_left--;
                reads_done++;
                chk("rd_ahead_bound", (reads_done - 4 * words_acc) <= 8, 1);
            end
            if (start && !busy && len == 0) done_due = 1'b1;
            rd_pend = acc_rd_en;
            rd_pend_addr = acc_rd_addr;
        end
    end

    task automatic run_job(input logic [AW-1:0] b, input int n);
        for (int i = 0; i < 500 && busy; i++) @(posedge clk);
        build_model(b, n);
        exp_addr = b;
        reads_left = n;
        reads_done = 0;
        words_acc = 0;
        first_valid_cyc = -1;
        job_done_seen = 1'b0;
        got.delete();
        @(posedge clk);
        #1;
        start = 1'b1;
        rd_base = b;
        len = (AW + 1)'(n);
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !job_done_seen; i++) @(posedge clk);
        chk("job_done_reached", job_done_seen, 1);
        chk("model_queue_empty", expq.size(), 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 1) == 1) mem[i] = SW'($urandom);
            else mem[i] = SW'(int'($urandom_range(0, 65535)) - 32768);
        end
    endtask

    initial begin
        fill_random();
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", acc_rd_en, 0);
        chk("rst_rd_addr", acc_rd_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_sat", sat_cnt, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Full job, no stall
        for (int k = 1; k <= 8; k++) mem[k - 1] = SW'(k << 8);
        ready_mode = 1;
        run_job(8'd0, 8);
        wait_done(200);
        chk("t1_words", got.size(), 2);
        if (got.size() == 2) begin
            chk("t1_word0", got[0], 32'h04030201);
            chk("t1_word1", got[1], 32'h08070605);
        end
        chk("t1_first_valid_cycle", first_valid_cyc - start_cyc, 6);
        chk("t1_sat", sat_cnt, 0);

        // Saturation
        mem[16] = 20'h07F00; mem[17] = 20'h08000; mem[18] = 20'h80000; mem[19] = 20'hFFF00;
        run_job(8'd16, 4);
        wait_done(200);
        chk("t2_words", got.size(), 1);
        if (got.size() == 1) chk("t2_word", got[0], 32'hFF807F7F);
        chk("t2_sat", sat_cnt, 2);

        // Partial word with address wrap
        mem[254] = 20'h01100; mem[255] = 20'h02200; mem[0] = 20'h03300;
        mem[1] = 20'h04400; mem[2] = 20'h05500;
        run_job(8'd254, 5);
        wait_done(200);
        chk("t3_words", got.size(), 2);
        if (got.size() == 2) begin
            chk("t3_word0", got[0], 32'h44332211);
            chk("t3_word1", got[1], 32'h00000055);
        end

        // Backpressure: random ready plus a 20-cycle hold low
        fill_random();
        ready_mode = 2;
        run_job(8'($urandom), 64);
        repeat (12) @(posedge clk);
        ready_mode = 0;
        repeat (20) @(posedge clk);
        ready_mode = 2;
        wait_done(2000);
        chk("t4_words", got.size(), 16);

        // len = 0
        run_job(8'd7, 0);
        wait_done(20);
        chk("t5_words", got.size(), 0);
        chk("t5_sat", sat_cnt, 0);

        // start during busy is ignored
        run_job(8'd100, 37);
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1; rd_base = 8'd3; len = 9'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(2000);
        chk("t6_words", got.size(), 10);

        // len = 256
        run_job(8'($urandom), 256);
        wait_done(5000);
        chk("t7_words", got.size(), 64);

        // Reset while stalled with out_valid high
        ready_mode = 0;
        run_job(8'd0, 64);
        for (int i = 0; i < 50 && !out_valid; i++) @(posedge clk);
        chk("t8_stalled_valid", out_valid, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_rst_busy", busy, 0);
        chk("t8_rst_valid", out_valid, 0);
        chk("t8_rst_data", out_data, 0);
        chk("t8_rst_rd_en", acc_rd_en, 0);
        chk("t8_rst_sat", sat_cnt, 0);
        expq.delete();
        reads_left = 0;
        done_due = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        ready_mode = 1;
        mem[0] = 20'h00100; mem[1] = 20'h00200; mem[2] = 20'h00300; mem[3] = 20'h00400;
        run_job(8'd0, 4);
        wait_done(200);
        chk("t8_words", got.size(), 1);
        if (got.size() == 1) chk("t8_word", got[0], 32'h04030201);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
